// File: rtl/sample_interp.sv
// Moves NCO samples from the audio_clock domain into CLOCK_50 and linearly interpolates between them.
// Capture lands SYNC_STAGES+1 clocks after an audio_clock fall; dout starts moving two clocks later.
module sample_interp #(
  parameter int WIDTH       = 12,
  parameter int LOG2_STEPS  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int INTERP      = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             audio_clock,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             sample_strobe,
  output logic             overrun
);

  localparam int ACC_W = WIDTH + 1 + LOG2_STEPS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ac_d;
  logic                   fall;
  logic                   load;
  logic [WIDTH-1:0]       target;
  logic                   ramp_busy;
  logic                   ramp_step;
  logic                   count_done;
  logic [WIDTH-1:0]       ramp_dout;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync <= '0;
      ac_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], audio_clock};
      ac_d <= sync[SYNC_STAGES-1];
    end
  end

  // Sampling on the falling edge puts us mid-period of din, so no bus synchroniser is needed.
  assign fall = ac_d & ~sync[SYNC_STAGES-1];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      target        <= '0;
      sample_strobe <= 1'b0;
      overrun       <= 1'b0;
      load          <= 1'b0;
    end else begin
      sample_strobe <= fall;
      overrun       <= fall & ramp_busy;
      load          <= fall;
      if (fall) begin
        target <= din;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A new load outranks a ramp completing in the same cycle.
  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = (INTERP != 0) ? RAMP : HOLD;
    end else if (state == RAMP && count_done) begin
      state_nx = HOLD;
    end
  end

  always_comb begin
    ramp_busy = (state == RAMP);
    ramp_step = (state == RAMP) && !load;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (load && INTERP == 0) begin
      dout <= target;
    end else if (ramp_step) begin
      dout <= ramp_dout;
    end
  end

  generate
    if (INTERP != 0) begin : g_ramp
      logic signed [WIDTH:0]       delta;
      logic signed [ACC_W-1:0]     acc;
      logic signed [ACC_W-1:0]     acc_nx;
      logic [WIDTH-1:0]            start;
      logic [LOG2_STEPS-1:0]       count;

      assign acc_nx = acc + {{LOG2_STEPS{delta[WIDTH]}}, delta};

      // The true sum always lies between start and target, so modulo-2^WIDTH addition is exact.
      assign ramp_dout  = start + acc_nx[WIDTH+LOG2_STEPS-1:LOG2_STEPS];
      assign count_done = &count;

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          delta <= '0;
          acc   <= '0;
          start <= '0;
          count <= '0;
        end else if (load) begin
          start <= dout;
          delta <= {1'b0, target} - {1'b0, dout};
          acc   <= '0;
          count <= '0;
        end else if (ramp_step) begin
          acc   <= acc_nx;
          count <= count + 1'b1;
        end
      end
    end else begin : g_hold
      assign ramp_dout  = '0;
      assign count_done = 1'b0;
    end
  endgenerate

endmodule
